debounce_pulse: RTL and testbench
=================================

# debounce_pulse

- Input conditioning stage that sits directly upstream of the serial-input FSMs.
- Takes a raw asynchronous, bouncy input (push-button or switch) and synchronises it into `clk`.
- Filters bounce and emits a clean debounced level plus single-cycle press/release pulses.
- The `press_pulse` output drives the `in` port of the downstream 2-state toggle FSM, so one physical press causes exactly one state flip.

## Interface
- `STABLE_CYCLES`, default 8: consecutive synchronised cycles of the new value required before the level changes. Legal range 2–255.
- `CNT_W`, default 8: width of `press_count`.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: reset, asynchronous, active-high.
- `btn_raw` input 1: raw asynchronous input; may change at any time.
- `btn_level` output 1: debounced level.
- `press_pulse` output 1: one-cycle high on a debounced 0→1 transition.
- `release_pulse` output 1: one-cycle high on a debounced 1→0 transition.
- `busy` output 1: high while a candidate transition is being qualified (WAIT states).
- `press_count` output CNT_W: number of qualified presses, wraps modulo 2^CNT_W.

## Operation
**Synchroniser**
- Two flops, `s1 <= btn_raw` and `s2 <= s1`; both reset to 0.
- All other logic uses only `s2`.

**FSM** (registered state, reset to `IDLE_LO`):
- `IDLE_LO`:
  - `s2==1` → `WAIT_HI`, `cnt <= 0`.
  - Else stay.
- `WAIT_HI`:
  - `s2==0` → `IDLE_LO`, `cnt <= 0` (bounce rejected, no outputs).
  - `s2==1` and `cnt==STABLE_CYCLES-1` → `IDLE_HI`; `btn_level <= 1`, `press_pulse <= 1`, `press_count <= press_count+1`.
  - Otherwise `cnt <= cnt+1`.
- `IDLE_HI`:
  - `s2==0` → `WAIT_LO`, `cnt <= 0`.
- `WAIT_LO`:
  - `s2==1` → `IDLE_HI`, `cnt <= 0`.
  - `s2==0` and `cnt==STABLE_CYCLES-1` → `IDLE_LO`; `btn_level <= 0`, `release_pulse <= 1`.
  - Otherwise `cnt <= cnt+1`.
- Unreachable encodings → `IDLE_LO`, `cnt <= 0`.

**Outputs**
- `press_pulse` and `release_pulse` are registered. They default to 0 every cycle and are high for exactly one cycle, never both in the same cycle.
- `busy` is combinational from state: 1 in `WAIT_HI` or `WAIT_LO`.
- `press_count` increments only on a qualified press. It wraps from 2^CNT_W−1 to 0 with no flag.
- The qualification counter `cnt` is $clog2(STABLE_CYCLES) bits wide and never exceeds STABLE_CYCLES−1.

## Timing
- **Reset values:** `btn_level=0`, `press_pulse=0`, `release_pulse=0`, `busy=0`, `press_count=0`, state `IDLE_LO`, `cnt=0`, `s1=s2=0`.
- **Reset mid-qualification or while high:** immediately returns to the above. No pulse is generated, even if `btn_raw` is still high. After reset deasserts, a held-high input is then re-qualified as a fresh press.
- **Latency:** `btn_raw` stable from sampling edge E0.
  - `s2` is high after E1.
  - FSM enters `WAIT_HI` at E2.
  - `btn_level` and `press_pulse` assert after edge E2+STABLE_CYCLES, i.e. STABLE_CYCLES+3 edges after the first sampling edge.
  - Release latency is identical.
- **Bounce rejection:** any glitch seen on `s2` during WAIT restarts qualification from the IDLE state. A glitch shorter than one clock may be missed entirely, which is acceptable.
- **Back-to-back events:** the minimum spacing between a press pulse and the following release pulse is STABLE_CYCLES+1 cycles.
- **Downstream use:** `press_pulse` is high for exactly one rising edge of `clk`, so the downstream FSM samples it once.

## Structure
- Shared package `debounce_pkg` holds:
  - the 2-bit state encoding (`IDLE_LO=2'd0`, `WAIT_HI=2'd1`, `IDLE_HI=2'd2`, `WAIT_LO=2'd3`);
  - the default `STABLE_CYCLES` constant.
- Sub-module `sync2`: 2-flop synchroniser with async active-high reset, reusable for other external inputs.
- The FSM, qualification counter and press counter live in `debounce_pulse`.

## Test plan
All scenarios use STABLE_CYCLES=4.
- **Reset hold:** `reset=1`, `btn_raw=1` → all outputs 0. Release reset with `btn_raw` held 1 → `press_pulse` high exactly one cycle, 7 edges after the first sampling edge; `press_count=1`; `btn_level=1`.
- **Bounce rejection:** `btn_raw` toggles 1,0,1,0 each cycle for 8 cycles then stays 0 → no pulses; `btn_level=0`; `press_count=0`; `busy` high intermittently.
- **Press/release cycle:** hold 1 for 12 cycles, then 0 for 12 cycles → one `press_pulse` and one `release_pulse`, each one cycle wide; `btn_level` returns to 0.
- **Bounce on release:** from `btn_level=1`, drop to 0 for 2 cycles then back to 1 → `WAIT_LO` aborts; no `release_pulse`; `btn_level` stays 1.
- **Counter wrap:** CNT_W=2, five clean presses → `press_count` sequence 1,2,3,0,1.
- **Async reset mid-WAIT:** assert `reset` while `busy=1` → outputs clear immediately without waiting for a clock edge; no pulse after release unless re-qualified.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the button debounce/pulse stage: state encoding and default qualification length.
package debounce_pkg;

    localparam int unsigned STABLE_CYCLES_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } db_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, async active-high reset.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/debounce_pulse.sv
// Debounces a raw button into a clean level plus one-cycle press/release pulses and a press counter.
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_raw_i,
    output logic             btn_level_o,
    output logic             press_pulse_o,
    output logic             release_pulse_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] press_count_o
);

    localparam int unsigned QW = $clog2(STABLE_CYCLES);
    localparam logic [QW-1:0] Q_LAST = QW'(STABLE_CYCLES - 1);

    logic             s2;
    db_state_e        state_q, state_d;
    logic [QW-1:0]    cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [CNT_W-1:0] count_q, count_d;

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_raw_i),
        .q_o   (s2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE_LO;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
        end
    end

    // Any sample disagreeing with the candidate level during WAIT drops back to the old IDLE state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        count_d   = count_q;
        case (state_q)
            IDLE_LO: begin
                if (s2) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s2) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == Q_LAST) begin
                    state_d = IDLE_HI;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + QW'(1);
                end
            end
            IDLE_HI: begin
                if (!s2) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s2) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == Q_LAST) begin
                    state_d   = IDLE_LO;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + QW'(1);
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    assign btn_level_o     = level_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
    assign press_count_o   = count_q;
    assign busy_o          = (state_q == WAIT_HI) || (state_q == WAIT_LO);

endmodule

// File: tb/tb_debounce_pulse.sv
// Scoreboard bench for debounce_pulse: two instances (8-bit and 2-bit press counters) share one stimulus.
module tb_debounce_pulse;

    localparam int unsigned STABLE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_raw = 1'b0;

    logic       level8, pp8, rp8, busy8;
    logic [7:0] cnt8;
    logic       level2, pp2, rp2, busy2;
    logic [1:0] cnt2;

    typedef struct {
        bit kind;
        int cyc;
        int cnt;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  exp_presses = 0;

    debounce_pulse #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut8 (
        .clk             (clk),
        .reset           (reset),
        .btn_raw_i       (btn_raw),
        .btn_level_o     (level8),
        .press_pulse_o   (pp8),
        .release_pulse_o (rp8),
        .busy_o          (busy8),
        .press_count_o   (cnt8)
    );

    debounce_pulse #(.STABLE_CYCLES(STABLE), .CNT_W(2)) dut2 (
        .clk             (clk),
        .reset           (reset),
        .btn_raw_i       (btn_raw),
        .btn_level_o     (level2),
        .press_pulse_o   (pp2),
        .release_pulse_o (rp2),
        .busy_o          (busy2),
        .press_count_o   (cnt2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected pulse appears STABLE+3 edges after the first sampling edge of the new value.
    task automatic push_ev(input bit k);
        ev_t e;
        if (k) exp_presses++;
        e.kind = k;
        e.cyc  = cyc + int'(STABLE) + 3;
        e.cnt  = exp_presses;
        sb.push_back(e);
    endtask

    task automatic hold(input logic v, input int n);
        btn_raw = v;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse must match the head of the scoreboard; overdue entries are misses.
    always @(negedge clk) begin
        if (!reset) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event: kind=%0d expected at cycle %0d, still absent at cycle %0d",
                         sb[0].kind, sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (pp8 || rp8 || pp2 || rp2) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: cycle %0d press=%0b/%0b release=%0b/%0b required no pulse",
                             cyc, pp8, pp2, rp8, rp2);
                end else begin
                    mon_e = sb.pop_front();
                    if ({pp8, rp8, pp2, rp2} !== {mon_e.kind, !mon_e.kind, mon_e.kind, !mon_e.kind}) begin
                        errors++;
                        $display("FAIL pulse_kind: got {pp8,rp8,pp2,rp2}=%b required kind=%0d",
                                 {pp8, rp8, pp2, rp2}, mon_e.kind);
                    end
                    checks++;
                    if (cyc !== mon_e.cyc) begin
                        errors++;
                        $display("FAIL pulse_latency: pulse at cycle %0d required %0d", cyc, mon_e.cyc);
                    end
                    checks++;
                    if (level8 !== mon_e.kind || level2 !== mon_e.kind || busy8 !== 1'b0) begin
                        errors++;
                        $display("FAIL level_at_pulse: level=%b/%b busy=%b required level=%0d busy=0",
                                 level8, level2, busy8, mon_e.kind);
                    end
                    checks++;
                    if (cnt8 !== 8'(mon_e.cnt) || cnt2 !== 2'(mon_e.cnt)) begin
                        errors++;
                        $display("FAIL count_at_pulse: got %0d/%0d required %0d/%0d",
                                 cnt8, cnt2, 8'(mon_e.cnt), 2'(mon_e.cnt));
                    end
                end
            end
        end
    end

    task automatic test_reset;
        reset   = 1'b1;
        btn_raw = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({level8, pp8, rp8, busy8, level2, pp2, rp2, busy2} !== 8'b0 || cnt8 !== 8'd0 || cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_hold: flags=%b cnt=%0d/%0d required all zero",
                     {level8, pp8, rp8, busy8, level2, pp2, rp2, busy2}, cnt8, cnt2);
        end
        reset       = 1'b0;
        exp_presses = 0;
        push_ev(1'b1);
        hold(1'b1, 12);
        checks++;
        if (level8 !== 1'b1 || cnt8 !== 8'd1 || cnt2 !== 2'd1 || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_release_press: level=%b cnt=%0d/%0d pending=%0d required level=1 cnt=1 pending=0",
                     level8, cnt8, cnt2, sb.size());
        end
        push_ev(1'b0);
        hold(1'b0, 12);
        checks++;
        if (level8 !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_release_low: level=%b pending=%0d required level=0 pending=0", level8, sb.size());
        end
    endtask

    task automatic test_bounce;
        bit busy_seen = 0;
        int start_cnt = exp_presses;
        for (int i = 0; i < 8; i++) begin
            btn_raw = (i % 2 == 0);
            @(negedge clk);
            if (busy8) busy_seen = 1;
        end
        btn_raw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy8) busy_seen = 1;
        end
        checks++;
        if (level8 !== 1'b0 || cnt8 !== 8'(start_cnt) || busy8 !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL bounce_reject: level=%b cnt=%0d busy=%b required level=0 cnt=%0d busy=0",
                     level8, cnt8, busy8, start_cnt);
        end
        checks++;
        if (!busy_seen) begin
            errors++;
            $display("FAIL bounce_busy: busy never seen high, required intermittent high");
        end
    endtask

    task automatic test_press_release;
        push_ev(1'b1);
        hold(1'b1, 12);
        checks++;
        if (level8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL press_level: level=%b busy=%b required level=1 busy=0", level8, busy8);
        end
        push_ev(1'b0);
        hold(1'b0, 12);
        checks++;
        if (level8 !== 1'b0 || cnt8 !== 8'(exp_presses) || sb.size() != 0) begin
            errors++;
            $display("FAIL release_level: level=%b cnt=%0d required level=0 cnt=%0d",
                     level8, cnt8, exp_presses);
        end
    endtask

    task automatic test_release_bounce;
        bit busy_seen = 0;
        push_ev(1'b1);
        hold(1'b1, 12);
        btn_raw = 1'b0;
        repeat (2) @(negedge clk);
        btn_raw = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (busy8) busy_seen = 1;
        end
        checks++;
        if (level8 !== 1'b1 || !busy_seen || busy8 !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL release_bounce: level=%b busy_seen=%0d busy=%b required level=1 busy_seen=1 busy=0",
                     level8, busy_seen, busy8);
        end
        push_ev(1'b0);
        hold(1'b0, 12);
        checks++;
        if (level8 !== 1'b0) begin
            errors++;
            $display("FAIL release_after_bounce: level=%b required 0", level8);
        end
    endtask

    task automatic test_counter_wrap;
        logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        reset   = 1'b1;
        btn_raw = 1'b0;
        repeat (2) @(negedge clk);
        reset       = 1'b0;
        exp_presses = 0;
        for (int i = 0; i < 5; i++) begin
            push_ev(1'b1);
            hold(1'b1, 10);
            checks++;
            if (cnt2 !== seq[i] || cnt8 !== 8'(i + 1)) begin
                errors++;
                $display("FAIL wrap_step%0d: cnt2=%0d cnt8=%0d required %0d/%0d", i, cnt2, cnt8, seq[i], i + 1);
            end
            push_ev(1'b0);
            hold(1'b0, 10);
        end
    endtask

    task automatic test_async_reset;
        btn_raw = 1'b1;
        for (int i = 0; i < 10 && !busy8; i++) @(negedge clk);
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL async_busy_wait: busy=%b required 1 within 10 cycles", busy8);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({level8, pp8, rp8, busy8, busy2} !== 5'b0 || cnt8 !== 8'd0 || cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_clear: flags=%b cnt=%0d/%0d required all zero",
                     {level8, pp8, rp8, busy8, busy2}, cnt8, cnt2);
        end
        @(negedge clk);
        repeat (2) @(negedge clk);
        reset       = 1'b0;
        exp_presses = 0;
        push_ev(1'b1);
        hold(1'b1, 12);
        checks++;
        if (level8 !== 1'b1 || cnt8 !== 8'd1 || sb.size() != 0) begin
            errors++;
            $display("FAIL async_requalify: level=%b cnt=%0d required level=1 cnt=1", level8, cnt8);
        end
        push_ev(1'b0);
        hold(1'b0, 12);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_bounce();
        test_press_release();
        test_release_bounce();
        test_counter_wrap();
        test_async_reset();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d events still pending, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
